// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose: FSM state encodings and the wait-state counter width, shared by
// the responder top and anything that needs to decode its state.
// Ports: none (package).

package data_mem_responder_pkg;

  // Responder FSM states.
  //   DM_IDLE : ready, stall low, a request may be accepted
  //   DM_WAIT : counting down programmed wait states
  //   DM_RESP : single response cycle, ack or err high
  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  // Wait-state counter width; covers WAIT_CYCLES in 0..15.
  localparam int DM_CNT_W = 4;

  // Counter load value for a given wait-state setting, clamped to the
  // counter range so an out-of-range parameter cannot wrap silently.
  function automatic logic [DM_CNT_W-1:0] dm_wait_load(input int cycles);
    if (cycles > (2 ** DM_CNT_W) - 1) begin
      return {DM_CNT_W{1'b1}};
    end
    return DM_CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/dm_ram_bytelane.sv
// rtl/dm_ram_bytelane.sv - word-organised RAM with per-byte-lane write enables
//
// Purpose: DEPTH x DWIDTH storage, synchronous write with one enable per
// byte lane, synchronous read. No reset: contents survive responder reset.
// Ports:
//   clk    in   clock, rising edge
//   addr   in   word index (shared by read and write)
//   we     in   write strobe, qualified per lane by sel
//   sel    in   byte-lane enables
//   wdata  in   lane-aligned write data
//   re     in   read strobe; rdata updates only when high
//   rdata  out  registered read data

module dm_ram_bytelane #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic                  we,
  input  logic [DWIDTH/8-1:0]   sel,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic                  re,
  output logic [DWIDTH-1:0]     rdata
);

  localparam int LANES = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        if (sel[l]) begin
          mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder with wait states for the core memory stage
//
// Purpose: accepts one strobe/ack bus request at a time, waits WAIT_CYCLES
// cycles, then completes it against a byte-lane RAM with a one-cycle ack
// (or err for an out-of-range word or an empty lane mask).
// Ports:
//   dm_clk      in   clock, rising edge
//   dm_rst      in   asynchronous active-low reset
//   dm_i_cyc    in   bus cycle in progress; low during WAIT aborts
//   dm_i_stb    in   request strobe
//   dm_i_we     in   1 = store, 0 = load
//   dm_i_addr   in   byte address; word index is addr[AWIDTH_MEM-1:2]
//   dm_i_wdata  in   lane-aligned store data
//   dm_i_sel    in   byte-lane enables
//   dm_o_stall  out  busy, requests ignored while high
//   dm_o_ack    out  one-cycle completion pulse
//   dm_o_err    out  one-cycle error pulse, replaces ack
//   dm_o_rdata  out  load data, non-zero only alongside a load ack

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH_MEM  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    dm_clk,
  input  logic                    dm_rst,
  input  logic                    dm_i_cyc,
  input  logic                    dm_i_stb,
  input  logic                    dm_i_we,
  input  logic [AWIDTH_MEM-1:0]   dm_i_addr,
  input  logic [DWIDTH-1:0]       dm_i_wdata,
  input  logic [DWIDTH/8-1:0]     dm_i_sel,
  output logic                    dm_o_stall,
  output logic                    dm_o_ack,
  output logic                    dm_o_err,
  output logic [DWIDTH-1:0]       dm_o_rdata
);

  localparam int LANES  = DWIDTH / 8;
  localparam int IDX_W  = AWIDTH_MEM - 2;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AWIDTH_MEM-1:0] DEPTH_WORDS = AWIDTH_MEM'(DEPTH);
  localparam logic [DM_CNT_W-1:0]   CNT_LOAD    = dm_wait_load(WAIT_CYCLES);
  localparam logic [DM_CNT_W-1:0]   CNT_ONE     = DM_CNT_W'(1);

  dm_state_t state;
  dm_state_t next_state;

  logic [DM_CNT_W-1:0] cnt;

  // Request captured at accept.
  logic                lat_we;
  logic [IDX_W-1:0]    lat_idx;
  logic [DWIDTH-1:0]   lat_wdata;
  logic [LANES-1:0]    lat_sel;

  // Request as seen at the response edge. In IDLE this is the live bus so
  // that WAIT_CYCLES=0 can complete on the accept edge itself.
  logic                req_we;
  logic [IDX_W-1:0]    req_idx;
  logic [DWIDTH-1:0]   req_wdata;
  logic [LANES-1:0]    req_sel;

  logic                accept;
  logic                resp_fire;
  logic                req_err;
  logic                ram_we;
  logic                ram_re;

  logic                ack_q;
  logic                err_q;
  logic                stall_q;
  logic                rd_valid_q;
  logic [DWIDTH-1:0]   ram_q;

  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^dm_i_addr[1:0];

  assign accept = (state == DM_IDLE) && dm_i_cyc && dm_i_stb;

  always_comb begin
    req_we    = lat_we;
    req_idx   = lat_idx;
    req_wdata = lat_wdata;
    req_sel   = lat_sel;
    if (state == DM_IDLE) begin
      req_we    = dm_i_we;
      req_idx   = dm_i_addr[AWIDTH_MEM-1:2];
      req_wdata = dm_i_wdata;
      req_sel   = dm_i_sel;
    end
  end

  // Next-state and response-edge decode.
  always_comb begin
    next_state = state;
    case (state)
      DM_IDLE: begin
        if (accept) begin
          next_state = (WAIT_CYCLES == 0) ? DM_RESP : DM_WAIT;
        end
      end
      DM_WAIT: begin
        if (!dm_i_cyc) begin
          next_state = DM_IDLE;
        end else if (cnt <= CNT_ONE) begin
          next_state = DM_RESP;
        end
      end
      DM_RESP: begin
        next_state = DM_IDLE;
      end
      default: begin
        next_state = DM_IDLE;
      end
    endcase
  end

  // The edge that enters RESP is the one that commits the RAM access.
  assign resp_fire = (next_state == DM_RESP) && (state != DM_RESP);
  assign req_err   = ({2'b00, req_idx} >= DEPTH_WORDS) || (req_sel == '0);
  assign ram_we    = resp_fire && req_we && !req_err;
  assign ram_re    = resp_fire && !req_we && !req_err;

  always_ff @(posedge dm_clk or negedge dm_rst) begin
    if (!dm_rst) begin
      state      <= DM_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      lat_sel    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state <= next_state;

      if (accept) begin
        lat_we    <= dm_i_we;
        lat_idx   <= dm_i_addr[AWIDTH_MEM-1:2];
        lat_wdata <= dm_i_wdata;
        lat_sel   <= dm_i_sel;
        cnt       <= CNT_LOAD;
      end else if (state == DM_WAIT) begin
        cnt <= (next_state == DM_WAIT) ? (cnt - CNT_ONE) : '0;
      end

      ack_q      <= resp_fire && !req_err;
      err_q      <= resp_fire && req_err;
      rd_valid_q <= ram_re;
      stall_q    <= (next_state != DM_IDLE);
    end
  end

  dm_ram_bytelane #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk    (dm_clk),
    .addr   (req_idx[RAM_AW-1:0]),
    .we     (ram_we),
    .sel    (req_sel),
    .wdata  (req_wdata),
    .re     (ram_re),
    .rdata  (ram_q)
  );

  // The RAM read register has no reset, so its word is exposed only during
  // a load ack; the qualifier is a reset flop, which also clears rdata
  // asynchronously and forces it to zero for stores and errors.
  assign dm_o_rdata = rd_valid_q ? ram_q : '0;
  assign dm_o_ack   = ack_q;
  assign dm_o_err   = err_q;
  assign dm_o_stall = stall_q;

endmodule
